// File: rtl/armleocpu_regfile_ctrl.sv
// Control stage for the 2-read/1-write integer register file: post-reset clear, x0 = 0, write forwarding.
// Macro ARMLEOCPU_REGFILE_CLEAR_EN enables the post-reset clear sweep of both storage lanes.

module armleocpu_regfile_ctrl_rport #(
   parameter int ELEMENTS_W = 5,
   parameter int WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic [ELEMENTS_W-1:0] rs_addr,
   input  logic                  rs_read,
   input  logic [ELEMENTS_W-1:0] rd_addr,
   input  logic                  rd_write,
   input  logic [WIDTH-1:0]      rd_wdata,
   output logic                  lane_read,
   output logic [ELEMENTS_W-1:0] lane_readaddress,
   input  logic [WIDTH-1:0]      lane_readdata,
   output logic [WIDTH-1:0]      rs_data
);

   logic             sel_zero;
   logic             sel_fwd;
   logic [WIDTH-1:0] fwd_data;

   assign lane_read        = run & rs_read;
   assign lane_readaddress = rs_addr;

   // Selects track the lane: they only move when the lane registers a new read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_zero <= 1'b1;
         sel_fwd  <= 1'b0;
         fwd_data <= '0;
      end else if (!run) begin
         sel_zero <= 1'b1;
         sel_fwd  <= 1'b0;
      end else if (rs_read) begin
         sel_zero <= (rs_addr == '0);
         sel_fwd  <= rd_write & (rd_addr == rs_addr) & (rs_addr != '0);
         fwd_data <= rd_wdata;
      end
   end

   assign rs_data = sel_zero ? '0 : (sel_fwd ? fwd_data : lane_readdata);

endmodule

module armleocpu_regfile_ctrl #(
   parameter int ELEMENTS_W = 5,
   parameter int WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  ready,
   input  logic [ELEMENTS_W-1:0] rs1_addr,
   input  logic                  rs1_read,
   output logic [WIDTH-1:0]      rs1_data,
   input  logic [ELEMENTS_W-1:0] rs2_addr,
   input  logic                  rs2_read,
   output logic [WIDTH-1:0]      rs2_data,
   input  logic [ELEMENTS_W-1:0] rd_addr,
   input  logic                  rd_write,
   input  logic [WIDTH-1:0]      rd_wdata,
   output logic [ELEMENTS_W-1:0] lane1_readaddress,
   output logic                  lane1_read,
   input  logic [WIDTH-1:0]      lane1_readdata,
   output logic [ELEMENTS_W-1:0] lane2_readaddress,
   output logic                  lane2_read,
   input  logic [WIDTH-1:0]      lane2_readdata,
   output logic [ELEMENTS_W-1:0] lane_writeaddress,
   output logic                  lane_write,
   output logic [WIDTH-1:0]      lane_writedata
);

   localparam int NUM_PORTS = 2;

   logic                                   run;
   logic [NUM_PORTS-1:0][ELEMENTS_W-1:0]   rs_addr;
   logic [NUM_PORTS-1:0]                   rs_read;
   logic [NUM_PORTS-1:0][ELEMENTS_W-1:0]   lane_raddr;
   logic [NUM_PORTS-1:0]                   lane_rd;
   logic [NUM_PORTS-1:0][WIDTH-1:0]        lane_rdata;
   logic [NUM_PORTS-1:0][WIDTH-1:0]        rs_data;

   assign rs_addr    = {rs2_addr, rs1_addr};
   assign rs_read    = {rs2_read, rs1_read};
   assign lane_rdata = {lane2_readdata, lane1_readdata};

   assign lane1_readaddress = lane_raddr[0];
   assign lane2_readaddress = lane_raddr[1];
   assign lane1_read        = lane_rd[0];
   assign lane2_read        = lane_rd[1];
   assign rs1_data          = rs_data[0];
   assign rs2_data          = rs_data[1];

   generate
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
         armleocpu_regfile_ctrl_rport #(
            .ELEMENTS_W (ELEMENTS_W),
            .WIDTH      (WIDTH)
         ) u_rport (
            .clk              (clk),
            .rst_n            (rst_n),
            .run              (run),
            .rs_addr          (rs_addr[p]),
            .rs_read          (rs_read[p]),
            .rd_addr          (rd_addr),
            .rd_write         (rd_write),
            .rd_wdata         (rd_wdata),
            .lane_read        (lane_rd[p]),
            .lane_readaddress (lane_raddr[p]),
            .lane_readdata    (lane_rdata[p]),
            .rs_data          (rs_data[p])
         );
      end
   endgenerate

`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
   localparam logic [0:0]            STATE_CLEAR = 1'b0;
   localparam logic [0:0]            STATE_RUN   = 1'b1;
   localparam logic [ELEMENTS_W-1:0] LAST_IDX    = {ELEMENTS_W{1'b1}};
   localparam logic [ELEMENTS_W-1:0] IDX_ONE     = 1;

   logic [0:0]            state;
   logic [ELEMENTS_W-1:0] clr_idx;

   // Counter parks on the last index; leaving CLEAR happens on that same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= STATE_CLEAR;
         clr_idx <= '0;
      end else if (state == STATE_CLEAR) begin
         if (clr_idx == LAST_IDX)
            state <= STATE_RUN;
         else
            clr_idx <= clr_idx + IDX_ONE;
      end
   end

   assign ready = (state == STATE_RUN);
   assign run   = ready;

   assign lane_write        = run ? (rd_write & (rd_addr != '0)) : 1'b1;
   assign lane_writeaddress = run ? rd_addr  : clr_idx;
   assign lane_writedata    = run ? rd_wdata : '0;
`else
   logic ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ready_q <= 1'b0;
      else
         ready_q <= 1'b1;
   end

   assign ready = ready_q;
   assign run   = ready_q;

   assign lane_write        = run & rd_write & (rd_addr != '0);
   assign lane_writeaddress = rd_addr;
   assign lane_writedata    = rd_wdata;
`endif

endmodule

// File: tb/tb_armleocpu_regfile_ctrl.sv
// Directed bench for armleocpu_regfile_ctrl with a behavioural model of both storage lanes.
// Checks the clear sweep when ARMLEOCPU_REGFILE_CLEAR_EN is defined, the one-edge startup otherwise.

module tb_armleocpu_regfile_ctrl;

   localparam int ELEMENTS_W = 5;
   localparam int WIDTH      = 32;
   localparam int ELEMENTS   = 2**ELEMENTS_W;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  ready;
   logic [ELEMENTS_W-1:0] rs1_addr, rs2_addr, rd_addr;
   logic                  rs1_read, rs2_read, rd_write;
   logic [WIDTH-1:0]      rs1_data, rs2_data, rd_wdata;
   logic [ELEMENTS_W-1:0] lane1_readaddress, lane2_readaddress, lane_writeaddress;
   logic                  lane1_read, lane2_read, lane_write;
   logic [WIDTH-1:0]      lane1_readdata, lane2_readdata, lane_writedata;

   int tests = 0;
   int fails = 0;

   logic             scramble;
   logic [WIDTH-1:0] mem [ELEMENTS];

   always #5 clk = ~clk;

   armleocpu_regfile_ctrl #(.ELEMENTS_W(ELEMENTS_W), .WIDTH(WIDTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ready             (ready),
      .rs1_addr          (rs1_addr),
      .rs1_read          (rs1_read),
      .rs1_data          (rs1_data),
      .rs2_addr          (rs2_addr),
      .rs2_read          (rs2_read),
      .rs2_data          (rs2_data),
      .rd_addr           (rd_addr),
      .rd_write          (rd_write),
      .rd_wdata          (rd_wdata),
      .lane1_readaddress (lane1_readaddress),
      .lane1_read        (lane1_read),
      .lane1_readdata    (lane1_readdata),
      .lane2_readaddress (lane2_readaddress),
      .lane2_read        (lane2_read),
      .lane2_readdata    (lane2_readdata),
      .lane_writeaddress (lane_writeaddress),
      .lane_write        (lane_write),
      .lane_writedata    (lane_writedata)
   );

   // Storage lanes: registered read, old data on read-during-write, hold when not reading.
   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < ELEMENTS; i++) mem[i] <= 32'hBAD0_0000 + i;
      end else begin
         if (lane1_read) lane1_readdata <= mem[lane1_readaddress];
         if (lane2_read) lane2_readdata <= mem[lane2_readaddress];
         if (lane_write) mem[lane_writeaddress] <= lane_writedata;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] a1, input logic r1, input logic [4:0] a2,
                        input logic r2, input logic [4:0] ad, input logic w,
                        input logic [31:0] d);
      rs1_addr = a1; rs1_read = r1; rs2_addr = a2; rs2_read = r2;
      rd_addr = ad; rd_write = w; rd_wdata = d;
      #1;
   endtask

   task automatic idle();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; scramble = 1'b1;
      idle();
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %0b want 0", ready); end
      tests++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
         fails++; $display("FAIL reset_rsdata got %h/%h want 0/0", rs1_data, rs2_data); end
`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
      tests++; if (lane_write !== 1'b1 || lane_writeaddress !== 5'd0 || lane_writedata !== 32'h0) begin
         fails++; $display("FAIL reset_lanewr got %b/%0d/%h want 1/0/0", lane_write, lane_writeaddress, lane_writedata); end
`else
      tests++; if (lane_write !== 1'b0) begin fails++; $display("FAIL reset_lanewr got %b want 0", lane_write); end
`endif
      cycle(); cycle();
      scramble = 1'b0;
      cycle();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_startup();
`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
      // Requests during the sweep must be ignored.
      drive(5'd5, 1'b1, 5'd31, 1'b1, 5'd7, 1'b1, 32'hFFFF_FFFF);
      for (int k = 0; k < ELEMENTS; k++) begin
         tests++; if (ready !== 1'b0 || lane_write !== 1'b1 || lane_writeaddress !== k[4:0] || lane_writedata !== 32'h0) begin
            fails++; $display("FAIL clear_step%0d got rdy=%b wr=%b a=%0d d=%h want 0/1/%0d/0",
                              k, ready, lane_write, lane_writeaddress, lane_writedata, k); end
         if (k == 0) begin
            tests++; if (lane1_read !== 1'b0 || lane2_read !== 1'b0) begin
               fails++; $display("FAIL clear_rd_gate got %b/%b want 0/0", lane1_read, lane2_read); end
         end
         cycle();
      end
      idle();
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL clear_ready got %b want 1", ready); end
      tests++; if (rs1_data !== 32'h0) begin fails++; $display("FAIL clear_sel_held got %h want 0", rs1_data); end
      drive(5'd5, 1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 32'h0);
      cycle();
      idle();
      tests++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
         fails++; $display("FAIL clear_zeroed got %h/%h want 0/0", rs1_data, rs2_data); end
`else
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL start_ready0 got %b want 0", ready); end
      cycle();
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL start_ready1 got %b want 1", ready); end
`endif
   endtask

   task automatic test_basic_rw();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'hDEAD_BEEF);
      tests++; if (lane_write !== 1'b1 || lane_writeaddress !== 5'd7 || lane_writedata !== 32'hDEAD_BEEF) begin
         fails++; $display("FAIL rw_lanewr got %b/%0d/%h want 1/7/deadbeef", lane_write, lane_writeaddress, lane_writedata); end
      cycle();
      drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
      tests++; if (lane1_read !== 1'b1 || lane1_readaddress !== 5'd7) begin
         fails++; $display("FAIL rw_lanerd got %b/%0d want 1/7", lane1_read, lane1_readaddress); end
      cycle();
      idle();
      tests++; if (rs1_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rw_data got %h want deadbeef", rs1_data); end
   endtask

   task automatic test_forward();
      drive(5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 32'h1234_5678);
      cycle();
      idle();
      tests++; if (rs1_data !== 32'h1234_5678 || rs2_data !== 32'h1234_5678) begin
         fails++; $display("FAIL fwd_both got %h/%h want 12345678", rs1_data, rs2_data); end
      drive(5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 32'h0);
      cycle();
      idle();
      tests++; if (rs2_data !== 32'h1234_5678) begin fails++; $display("FAIL fwd_stored got %h want 12345678", rs2_data); end
   endtask

   task automatic test_x0();
      drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF);
      tests++; if (lane_write !== 1'b0) begin fails++; $display("FAIL x0_drop got %b want 0", lane_write); end
      cycle();
      idle();
      tests++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
         fails++; $display("FAIL x0_read got %h/%h want 0/0", rs1_data, rs2_data); end
   endtask

   task automatic test_hold();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'hA5A5_A5A5);
      cycle();
      drive(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
      cycle();
      tests++; if (rs1_data !== 32'hA5A5_A5A5) begin fails++; $display("FAIL hold_first got %h want a5a5a5a5", rs1_data); end
      for (int i = 0; i < 4; i++) begin
         drive(5'd3, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h1);
         cycle();
         tests++; if (rs1_data !== 32'hA5A5_A5A5) begin
            fails++; $display("FAIL hold_cyc%0d got %h want a5a5a5a5", i, rs1_data); end
      end
      drive(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
      cycle();
      idle();
      tests++; if (rs1_data !== 32'h1) begin fails++; $display("FAIL hold_after got %h want 1", rs1_data); end
   endtask

   task automatic test_back_to_back();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 32'h0000_AAAA);
      cycle();
      drive(5'd10, 1'b1, 5'd11, 1'b1, 5'd11, 1'b1, 32'h0000_BBBB);
      cycle();
      drive(5'd13, 1'b1, 5'd10, 1'b1, 5'd13, 1'b1, 32'h0000_DDDD);
      tests++; if (rs1_data !== 32'h0000_AAAA || rs2_data !== 32'h0000_BBBB) begin
         fails++; $display("FAIL b2b_1 got %h/%h want 0000aaaa/0000bbbb", rs1_data, rs2_data); end
      cycle();
      idle();
      tests++; if (rs1_data !== 32'h0000_DDDD || rs2_data !== 32'h0000_AAAA) begin
         fails++; $display("FAIL b2b_2 got %h/%h want 0000dddd/0000aaaa", rs1_data, rs2_data); end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #1;
      tests++; if (ready !== 1'b0 || rs1_data !== 32'h0) begin
         fails++; $display("FAIL rstrun got rdy=%b d=%h want 0/0", ready, rs1_data); end
      cycle();
      rst_n = 1'b1;
      #1;
`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
      for (int i = 0; i < 10; i++) cycle();
      tests++; if (lane_writeaddress !== 5'd10) begin fails++; $display("FAIL mid_idx got %0d want 10", lane_writeaddress); end
      rst_n = 1'b0;
      #1;
      tests++; if (lane_writeaddress !== 5'd0) begin fails++; $display("FAIL mid_restart got %0d want 0", lane_writeaddress); end
      cycle();
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < ELEMENTS; k++) begin
         tests++; if (ready !== 1'b0 || lane_writeaddress !== k[4:0]) begin
            fails++; $display("FAIL mid_step%0d got rdy=%b a=%0d want 0/%0d", k, ready, lane_writeaddress, k); end
         cycle();
      end
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", ready); end
      drive(5'd3, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 32'h0);
      cycle();
      idle();
      tests++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
         fails++; $display("FAIL mid_rezero got %h/%h want 0/0", rs1_data, rs2_data); end
`else
      tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rst_ready0 got %b want 0", ready); end
      cycle();
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL rst_ready1 got %b want 1", ready); end
      drive(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
      cycle();
      idle();
      tests++; if (rs1_data !== 32'h1) begin fails++; $display("FAIL rst_keep got %h want 1", rs1_data); end
`endif
   endtask

   initial begin
      test_reset();
      test_startup();
      test_basic_rw();
      test_forward();
      test_x0();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/armleocpu_regfile_ctrl.md
# armleocpu_regfile_ctrl

Control stage wrapped around two single-lane register storage arrays, turning them into the core's 2-read/1-write integer register file. It owns everything the storage lanes cannot do themselves:
- clears every entry after reset, since storage has no reset;
- hard-wires x0 to zero;
- forwards a same-cycle write to a read of the same register, since storage returns old data on read-during-write.

Decode drives it upstream; both storage lanes sit directly downstream.

## Interface
Parameters:
- ELEMENTS_W, 5, register address width; ELEMENTS = 2**ELEMENTS_W entries
- WIDTH, 32, register data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ready  out  1  1 = register file usable; 0 while clearing
- rs1_addr  in  ELEMENTS_W  read port 1 address
- rs1_read  in  1  read port 1 enable
- rs1_data  out  WIDTH  read port 1 data, valid one cycle after rs1_read
- rs2_addr, rs2_read, rs2_data  same as port 1, for read port 2
- rd_addr  in  ELEMENTS_W  write address
- rd_write  in  1  write enable
- rd_wdata  in  WIDTH  write data
- lane1_readaddress  out  ELEMENTS_W  to lane 1 storage
- lane1_read  out  1  to lane 1 storage
- lane1_readdata  in  WIDTH  from lane 1 storage, registered inside the lane
- lane2_readaddress, lane2_read, lane2_readdata  same as lane 1, for lane 2
- lane_writeaddress  out  ELEMENTS_W  shared by both lanes
- lane_write  out  1  shared by both lanes
- lane_writedata  out  WIDTH  shared by both lanes

## Operation
- Two states: CLEAR and RUN.
  - CLEAR is entered on reset.
  - CLEAR moves to RUN after the last address is written.
  - RUN is held until the next reset.
- CLEAR behaviour:
  - Counter clr_idx starts at 0.
  - lane_write=1, lane_writeaddress=clr_idx, lane_writedata=0.
  - clr_idx increments each cycle and does not wrap: at ELEMENTS-1 the state goes to RUN.
  - ready=0. rd_write, rs1_read and rs2_read are ignored: lane reads are forced to 0 and output selects are held at zero.
- RUN, write path:
  - lane_write = rd_write & (rd_addr != 0); a write to x0 is dropped.
  - lane_writeaddress = rd_addr, lane_writedata = rd_wdata, combinational pass-through.
- RUN, read path (per port N):
  - laneN_read = rsN_read and laneN_readaddress = rsN_addr, combinational.
  - When rsN_read=1, the block registers:
    - sel_zero = (rsN_addr == 0);
    - sel_fwd = rd_write & (rd_addr == rsN_addr) & (rsN_addr != 0);
    - fwd_data = rd_wdata.
  - rsN_data = sel_zero ? 0 : sel_fwd ? fwd_data : laneN_readdata.
- When rsN_read=0, the select registers and fwd_data hold, so rsN_data holds its last value. The lane also holds its data in this case.
- Both ports forward independently. Both ports may read the same address in the same cycle.

## Timing
- Reset values:
  - state=CLEAR, clr_idx=0, ready=0;
  - sel_zero=1, sel_fwd=0, fwd_data=0, so rs1_data=rs2_data=0;
  - lane_write=1 with address 0, data 0 (clearing begins).
- Clear length: ready rises after exactly ELEMENTS rising edges following rst_n deassertion (32 with defaults). Address k is written on edge k+1.
- rst_n asserted mid-clear: restart from clr_idx=0.
- rst_n asserted in RUN: re-enter CLEAR. Storage contents are re-zeroed.
- Read latency is 1 cycle: address presented in cycle T, data on rsN_data in cycle T+1.
- A write in cycle T is visible to:
  - a read issued in cycle T, via forwarding;
  - reads issued in cycle T+1 and later, via storage.
- There is no back-pressure. While ready=0, upstream must stall.

## Configuration
- Macro: ARMLEOCPU_REGFILE_CLEAR_EN.
- Defined: CLEAR state and counter are present, with behaviour as above.
- Undefined:
  - No CLEAR state, no counter.
  - ready is reset to 0 and becomes 1 on the first rising edge after rst_n deassertion.
  - lane_write resets to 0.
  - Storage contents are undefined until written. x0 still reads 0, and write-to-x0 is still dropped.

## Test plan
- Clear sweep (macro on): deassert rst_n → exactly 32 cycles with lane_write=1 and addresses 0..31 in order, data 0; then ready=1, and reads of x5 and x31 return 0.
- Basic write/read: write x7=0xDEADBEEF; next cycle rs1 reads x7 → rs1_data=0xDEADBEEF one cycle later.
- Forwarding: rd_write x9=0x12345678 in the same cycle as rs1_read x9 and rs2_read x9 → both outputs 0x12345678 next cycle, despite storage returning old data.
- x0 rules: write x0=0xFFFFFFFF → lane_write stays 0; rs2_read x0 → rs2_data=0, including when a same-cycle x0 write is issued.
- Hold: read x3 (=0xA5A5A5A5), then drop rs1_read for 4 cycles while writing x3=0x1 → rs1_data stays 0xA5A5A5A5.
- Reset mid-clear: assert rst_n low at clr_idx=10, release → clearing restarts at address 0, and ready rises 32 edges after release.
